// File: rtl/daq_multi_ch_counter.sv
// NUM_CH-channel A/Z window counter. Each channel counts synchronised A edges until a Z edge
// closes the window; results are tagged {ch, ovf, count} and queued in one shared FWFT FIFO.
module daq_multi_ch_counter #(
   parameter  int NUM_CH     = 4,
   parameter  int CNT_W      = 16,
   parameter  int FIFO_DEPTH = 8,
   localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int DW         = CHW + 1 + CNT_W,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              s00_axi_aclk,
   input  logic              s00_axi_aresetn,
   input  logic              I_ARM,
   input  logic [NUM_CH-1:0] I_CH_EN,
   input  logic              I_CLR,
   input  logic [NUM_CH-1:0] I_A,
   input  logic [NUM_CH-1:0] I_Z,
   input  logic              I_POP,
   output logic              O_VALID,
   output logic [DW-1:0]     O_DATA,
   output logic [LW-1:0]     O_LEVEL,
   output logic [NUM_CH-1:0] O_OVERFLOW,
   output logic              O_DROP
);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [NUM_CH-1:0] a_s1, a_s2, a_s3, a_edge;
   logic [NUM_CH-1:0] z_s1, z_s2, z_s3, z_edge;
   logic              arm_q;

   logic [CNT_W-1:0]  cnt      [NUM_CH];
   logic [CNT_W-1:0]  slot_cnt [NUM_CH];
   logic [NUM_CH-1:0] ovf_win, slot_ovf, pend, ovf_sticky;
   logic              drop;
   logic [NUM_CH-1:0] a_hit, z_hit, at_max, grant;
   logic [CHW-1:0]    grant_idx;
   logic              arm_rise, full, push, pop;
   logic [DW-1:0]     push_data;

   logic [DW-1:0]     ram [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     level;

   // Two synchroniser flops, a third stage for edge detection, and a registered strobe.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         a_s1   <= '0;
         a_s2   <= '0;
         a_s3   <= '0;
         a_edge <= '0;
         z_s1   <= '0;
         z_s2   <= '0;
         z_s3   <= '0;
         z_edge <= '0;
         arm_q  <= 1'b0;
      end else begin
         a_s1   <= I_A;
         a_s2   <= a_s1;
         a_s3   <= a_s2;
         a_edge <= a_s2 & ~a_s3;
         z_s1   <= I_Z;
         z_s2   <= z_s1;
         z_s3   <= z_s2;
         z_edge <= z_s2 & ~z_s3;
         arm_q  <= I_ARM;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      arm_rise  = I_ARM & ~arm_q;
      a_hit     = {NUM_CH{I_ARM}} & I_CH_EN & a_edge;
      z_hit     = {NUM_CH{I_ARM}} & I_CH_EN & z_edge;
      at_max    = '0;
      grant     = '0;
      grant_idx = '0;
      full      = (level == LW'(FIFO_DEPTH));
      for (int i = 0; i < NUM_CH; i++) at_max[i] = (cnt[i] == '1);
      // Scan downwards so the lowest pending channel wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pend[i]) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = CHW'(i);
         end
      end
      if (full) grant = '0;
   end

   assign push      = |grant;
   assign pop       = I_POP & O_VALID;
   assign push_data = {grant_idx, slot_ovf[grant_idx], slot_cnt[grant_idx]};

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]      <= '0;
            slot_cnt[i] <= '0;
         end
         ovf_win    <= '0;
         slot_ovf   <= '0;
         pend       <= '0;
         ovf_sticky <= '0;
         drop       <= 1'b0;
      end else if (I_CLR) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         ovf_win    <= '0;
         pend       <= '0;
         ovf_sticky <= '0;
         drop       <= 1'b0;
      end else begin
         pend <= pend & ~grant;
         for (int i = 0; i < NUM_CH; i++) begin
            if (arm_rise) begin
               cnt[i]     <= '0;
               ovf_win[i] <= 1'b0;
            end else if (z_hit[i]) begin
               // A same-cycle A edge belongs to the closing window; a new capture beats the drain.
               slot_cnt[i] <= (a_hit[i] && !at_max[i]) ? cnt[i] + CNT_W'(1) : cnt[i];
               slot_ovf[i] <= ovf_win[i] | (a_hit[i] & at_max[i]);
               pend[i]     <= 1'b1;
               if (pend[i] && !grant[i]) drop <= 1'b1;
               cnt[i]      <= '0;
               ovf_win[i]  <= 1'b0;
            end else if (a_hit[i]) begin
               if (at_max[i]) ovf_win[i] <= 1'b1;
               else           cnt[i]     <= cnt[i] + CNT_W'(1);
            end
            if (!arm_rise && a_hit[i] && at_max[i]) ovf_sticky[i] <= 1'b1;
         end
      end
   end

   // NOTE: the result RAM is reset as well, so the whole block powers up in a known state.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) ram[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (I_CLR) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            ram[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end

   assign O_VALID    = (level != '0);
   assign O_DATA     = ram[rd_ptr];
   assign O_LEVEL    = level;
   assign O_OVERFLOW = ovf_sticky;
   assign O_DROP     = drop;

endmodule

// File: tb/tb_daq_multi_ch_counter.sv
// Self-checking bench for daq_multi_ch_counter (NUM_CH=2, CNT_W=8, FIFO_DEPTH=4): vector table,
// hand-written corner sequences, and a randomized run against a window-level reference queue.
module tb_daq_multi_ch_counter;
   localparam int NUM_CH     = 2;
   localparam int CNT_W      = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int DW         = 1 + 1 + CNT_W;
   localparam int LW         = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              arm = 1'b0;
   logic [NUM_CH-1:0] ch_en = '0;
   logic              clr = 1'b0;
   logic [NUM_CH-1:0] a_in = '0;
   logic [NUM_CH-1:0] z_in = '0;
   logic              pop_in = 1'b0;
   logic              valid;
   logic [DW-1:0]     data;
   logic [LW-1:0]     level;
   logic [NUM_CH-1:0] overflow;
   logic              drop;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int                ch;
      int                n_a;
      bit                coinc;
      logic [DW-1:0]     exp_data;
      logic [NUM_CH-1:0] exp_ovf;
   } vec_t;

   vec_t              vecs [8];
   logic [DW-1:0]     model_q [$];
   logic [NUM_CH-1:0] ovf_model;

   always #5 clk = ~clk;

   daq_multi_ch_counter #(
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .s00_axi_aclk   (clk),
      .s00_axi_aresetn(rst_n),
      .I_ARM          (arm),
      .I_CH_EN        (ch_en),
      .I_CLR          (clr),
      .I_A            (a_in),
      .I_Z            (z_in),
      .I_POP          (pop_in),
      .O_VALID        (valid),
      .O_DATA         (data),
      .O_LEVEL        (level),
      .O_OVERFLOW     (overflow),
      .O_DROP         (drop)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_a(input int ch);
      a_in[ch] = 1'b1;
      step(2);
      a_in[ch] = 1'b0;
      step(2);
   endtask

   task automatic pulse_z(input int ch);
      z_in[ch] = 1'b1;
      step(2);
      z_in[ch] = 1'b0;
      step(2);
   endtask

   task automatic pop_head();
      pop_in = 1'b1;
      step(1);
      pop_in = 1'b0;
   endtask

   // n counts every A edge of the window; with coinc the last one rises together with Z.
   // Returns two cycles after the Z rise, with Z already low again.
   task automatic run_window(input int ch, input int n, input bit coinc);
      int pre;
      pre = (coinc && n > 0) ? n - 1 : n;
      for (int k = 0; k < pre; k++) pulse_a(ch);
      z_in[ch] = 1'b1;
      if (coinc && n > 0) a_in[ch] = 1'b1;
      step(2);
      z_in[ch] = 1'b0;
      a_in[ch] = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int lat);
      lat = start;
      while (!valid && lat < 20) begin
         step(1);
         lat++;
      end
   endtask

   task automatic drain_model();
      logic [DW-1:0] exp;
      while (model_q.size() > 0) begin
         exp = model_q.pop_front();
         check("rand_valid", 32'(valid), 32'd1);
         check("rand_data", 32'(data), 32'(exp));
         pop_head();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int w;

      vecs[0] = '{0,   3, 1'b0, 10'h003, 2'b00};
      vecs[1] = '{1,   3, 1'b1, 10'h203, 2'b00};
      vecs[2] = '{1,   1, 1'b0, 10'h201, 2'b00};
      vecs[3] = '{0, 255, 1'b0, 10'h0FF, 2'b00};
      vecs[4] = '{0, 300, 1'b0, 10'h1FF, 2'b01};
      vecs[5] = '{0,   4, 1'b0, 10'h004, 2'b01};
      vecs[6] = '{1,   0, 1'b0, 10'h200, 2'b01};
      vecs[7] = '{0, 256, 1'b1, 10'h1FF, 2'b01};

      arm   = 1'b1;
      ch_en = 2'b11;
      #1;
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_drop", 32'(drop), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(2);

      // Table-driven windows: latency, entry contents and sticky overflow
      for (int i = 0; i < 8; i++) begin
         run_window(vecs[i].ch, vecs[i].n_a, vecs[i].coinc);
         wait_valid(2, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
         check($sformatf("vec%0d_level", i), 32'(level), 32'd1);
         check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
         pop_head();
         check($sformatf("vec%0d_level_after_pop", i), 32'(level), 32'd0);
         step(2);
      end

      // Simultaneous Z on both channels: ch0 first, ch1 one cycle later
      pulse_a(0);
      pulse_a(0);
      pulse_a(1);
      z_in = 2'b11;
      step(2);
      z_in = 2'b00;
      step(2);
      check("dualz_not_yet", 32'(valid), 32'd0);
      step(1);
      check("dualz_valid", 32'(valid), 32'd1);
      check("dualz_level1", 32'(level), 32'd1);
      check("dualz_head_ch0", 32'(data), 32'h002);
      step(1);
      check("dualz_level2", 32'(level), 32'd2);
      pop_head();
      check("dualz_second_ch1", 32'(data), 32'h201);
      pop_head();
      check("dualz_empty", 32'(level), 32'd0);
      step(2);

      // Asynchronous reset mid-window with a queued entry and overflow set
      run_window(1, 1, 1'b0);
      wait_valid(2, lat);
      pulse_a(0);
      pulse_a(0);
      pulse_a(0);
      check("prereset_valid", 32'(valid), 32'd1);
      check("prereset_overflow", 32'(overflow), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", 32'(valid), 32'd0);
      check("async_reset_level", 32'(level), 32'd0);
      check("async_reset_overflow", 32'(overflow), 32'd0);
      check("async_reset_drop", 32'(drop), 32'd0);
      step(1);
      rst_n = 1'b1;
      step(2);
      run_window(0, 2, 1'b0);
      wait_valid(2, lat);
      check("after_reset_data", 32'(data), 32'h002);
      pop_head();
      step(2);

      // Synchronous clear with I_ARM held
      run_window(1, 1, 1'b0);
      wait_valid(2, lat);
      pulse_a(0);
      pulse_a(0);
      pulse_a(0);
      clr = 1'b1;
      #1;
      check("clr_is_synchronous", 32'(valid), 32'd1);
      step(1);
      clr = 1'b0;
      check("clr_valid", 32'(valid), 32'd0);
      check("clr_level", 32'(level), 32'd0);
      run_window(0, 2, 1'b0);
      wait_valid(2, lat);
      check("after_clr_data", 32'(data), 32'h002);
      pop_head();
      step(2);

      // Channel disable holds the count and ignores Z
      pulse_a(0);
      pulse_a(0);
      ch_en[0] = 1'b0;
      pulse_a(0);
      pulse_a(0);
      pulse_a(0);
      pulse_z(0);
      step(6);
      check("disabled_z_ignored", 32'(valid), 32'd0);
      ch_en[0] = 1'b1;
      run_window(0, 1, 1'b0);
      wait_valid(2, lat);
      check("enable_hold_data", 32'(data), 32'h003);
      pop_head();
      step(2);

      // Disarmed pulses are ignored; re-arming zeroes the earlier count
      pulse_a(0);
      pulse_a(0);
      arm = 1'b0;
      pulse_a(0);
      pulse_a(0);
      pulse_a(0);
      pulse_z(0);
      step(6);
      check("disarmed_z_ignored", 32'(valid), 32'd0);
      arm = 1'b1;
      step(2);
      run_window(0, 1, 1'b0);
      wait_valid(2, lat);
      check("rearm_data", 32'(data), 32'h001);
      pop_head();
      step(2);

      // FIFO full: six windows, no pops
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         run_window(0, k, 1'b0);
         step(2);
      end
      step(8);
      check("full_level", 32'(level), 32'd4);
      check("full_drop", 32'(drop), 32'd1);
      check("full_head", 32'(data), 32'h001);
      pop_head();
      check("full_pop_no_push", 32'(level), 32'd3);
      step(1);
      check("full_refill", 32'(level), 32'd4);
      check("full_order_w2", 32'(data), 32'h002);
      pop_head();
      check("full_order_w3", 32'(data), 32'h003);
      pop_head();
      check("full_order_w4", 32'(data), 32'h004);
      pop_head();
      check("full_order_w6", 32'(data), 32'h006);
      pop_head();
      check("full_drained", 32'(level), 32'd0);
      check("drop_sticky", 32'(drop), 32'd1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      check("drop_cleared", 32'(drop), 32'd0);

      // Randomized windows against a window-level reference queue
      ovf_model = '0;
      for (int it = 0; it < 16; it++) begin
         int ch, oth, n, m;
         bit coinc;
         ch    = int'($urandom_range(0, 1));
         oth   = 1 - ch;
         n     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 270))
                                             : int'($urandom_range(0, 12));
         coinc = ($urandom_range(0, 1) == 1) && (n > 0);
         m     = int'($urandom_range(0, 3));
         ch_en[oth] = 1'b0;
         for (int k = 0; k < m; k++) pulse_a(oth);
         if ($urandom_range(0, 1) == 1) pulse_z(oth);
         ch_en[oth] = 1'b1;
         run_window(ch, n, coinc);
         model_q.push_back(DW'(ch * 512 + ((n > 255) ? 256 + 255 : n)));
         if (n > 255) ovf_model[ch] = 1'b1;
         w = 0;
         while (level != LW'(model_q.size()) && w < 20) begin
            step(1);
            w++;
         end
         check("rand_level", 32'(level), 32'(model_q.size()));
         check("rand_overflow", 32'(overflow), 32'(ovf_model));
         if (model_q.size() == 3 || $urandom_range(0, 1) == 1) drain_model();
         step(2);
      end
      drain_model();
      check("rand_final_level", 32'(level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
